spike_sample_feeder: RTL and testbench

//  Source end of the network input-sample handshake. Buffers host-written spike vectors in a FIFO.

---
 rtl/spike_sample_feeder.sv | 150 +++++++++++++++
 tb/tb_spike_sample_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_sample_feeder.sv
// Spike sample feeder: source end of the network input-sample handshake.
// Host-written spike vectors are queued in a small FIFO; one vector at a time
// is held in a presentation register that drives in_spikes / sample_ready.
// Each rising edge of the network's sample strobe consumes the presented
// vector and pulls the next one from the FIFO.
module spike_sample_feeder #(
  parameter int N_INPUTS = 4,
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [N_INPUTS-1:0] wr_data,
  output logic                wr_ready,
  input  logic                flush,
  input  logic                sample,
  output logic                sample_ready,
  output logic [N_INPUTS-1:0] in_spikes,
  output logic [PTR_W:0]      level,
  output logic                overflow,
  output logic                underrun
);

  localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [N_INPUTS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      level_q,  level_d;

  // Presentation register and status flags
  logic [N_INPUTS-1:0] cur_q, cur_d;
  logic                cur_vld_q, cur_vld_d;
  logic                overflow_q, overflow_d;
  logic                underrun_q, underrun_d;
  logic                sample_q;

  logic rise;
  logic have_data;
  logic push;
  logic pop;
  logic starve;

  // wr_ready looks only at the registered level, so a pop in the same cycle
  // never lets a write into a full FIFO.
  assign wr_ready  = (level_q != LEVEL_FULL);
  assign rise      = sample & ~sample_q;
  assign have_data = (level_q != '0);
  assign push      = ~flush & wr_valid & wr_ready;
  // Pop to fill an empty presentation slot (LOAD) or on a strobe edge (ADVANCE).
  assign pop       = ~flush & have_data & (rise | ~cur_vld_q);
  assign starve    = ~flush & rise & ~have_data;

  // Next-state logic for pointers, occupancy, presented vector and flags
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cur_d      = cur_q;
    cur_vld_d  = cur_vld_q;
    overflow_d = overflow_q;
    underrun_d = underrun_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      cur_d      = '0;
      cur_vld_d  = 1'b0;
      overflow_d = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (wr_valid && !wr_ready) begin
        overflow_d = 1'b1;
      end

      if (pop) begin
        // Reads the old head, so a push into the same slot this cycle is safe.
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        cur_d     = mem_q[rd_ptr_q];
        cur_vld_d = 1'b1;
      end else if (starve) begin
        cur_d      = '0;
        cur_vld_d  = 1'b0;
        underrun_d = 1'b1;
      end

      unique case ({push, pop})
        2'b10:   level_d = level_q + (PTR_W+1)'(1);
        2'b01:   level_d = level_q - (PTR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cur_q      <= '0;
      cur_vld_q  <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cur_q      <= cur_d;
      cur_vld_q  <= cur_vld_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      // Edge detector keeps tracking through flush cycles.
      sample_q   <= sample;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; level and pointers alone decide
    // which entries are meaningful, so stale contents are never observed.
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign sample_ready = cur_vld_q;
  assign in_spikes    = cur_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underrun     = underrun_q;

  // Occupancy can never pass DEPTH nor pop from an empty FIFO.
  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    level_q <= LEVEL_FULL);
  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
    !(pop && !have_data));

endmodule

// File: tb/tb_spike_sample_feeder.sv
// Bench for spike_sample_feeder: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_spike_sample_feeder;

  localparam int N_INPUTS = 4;
  localparam int DEPTH    = 8;
  localparam int PTR_W    = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                wr_valid = 1'b0;
  logic [N_INPUTS-1:0] wr_data = '0;
  logic                wr_ready;
  logic                flush = 1'b0;
  logic                sample = 1'b0;
  logic                sample_ready;
  logic [N_INPUTS-1:0] in_spikes;
  logic [PTR_W:0]      level;
  logic                overflow;
  logic                underrun;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N_INPUTS-1:0] m_q [$];
  logic [N_INPUTS-1:0] m_cur;
  logic                m_vld;
  logic                m_ovf;
  logic                m_und;
  logic                m_prev;

  spike_sample_feeder #(
    .N_INPUTS (N_INPUTS),
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .sample       (sample),
    .sample_ready (sample_ready),
    .in_spikes    (in_spikes),
    .level        (level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur  = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_und  = 1'b0;
    m_prev = 1'b0;
  endtask

  // One clock of the feeder's behaviour, expressed on a queue.
  task automatic model_step(input logic wv, input logic [N_INPUTS-1:0] wd,
                            input logic fl, input logic sm);
    bit rise_e;
    bit was_full;
    bit had;
    rise_e = sm && !m_prev;
    m_prev = sm;
    if (fl) begin
      m_q.delete();
      m_cur = '0;
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_und = 1'b0;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    had      = (m_q.size() > 0);
    if (rise_e) begin
      if (had) begin
        m_cur = m_q.pop_front();
        m_vld = 1'b1;
      end else begin
        m_cur = '0;
        m_vld = 1'b0;
        m_und = 1'b1;
      end
    end else if (!m_vld && had) begin
      m_cur = m_q.pop_front();
      m_vld = 1'b1;
    end
    if (wv) begin
      if (was_full) m_ovf = 1'b1;
      else          m_q.push_back(wd);
    end
  endtask

  task automatic check_all();
    check("in_spikes", 32'(in_spikes), 32'(m_cur));
    check("sample_ready", 32'(sample_ready), 32'(m_vld));
    check("level", 32'(level), m_q.size());
    check("wr_ready", 32'(wr_ready), 32'(m_q.size() != DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underrun", 32'(underrun), 32'(m_und));
  endtask

  // Drive one cycle of inputs, advance model on the edge, compare #1 later.
  task automatic cycle(input logic wv, input logic [N_INPUTS-1:0] wd,
                       input logic fl, input logic sm);
    wr_valid = wv;
    wr_data  = wd;
    flush    = fl;
    sample   = sm;
    @(posedge clk);
    model_step(wv, wd, fl, sm);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any clock.
  task automatic do_reset();
    wr_valid = 1'b0;
    flush    = 1'b0;
    sample   = 1'b0;
    rst      = 1'b1;
    #2;
    model_reset();
    check("rst_ready", 32'(sample_ready), 32'd0);
    check("rst_spikes", 32'(in_spikes), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    check("por_ready", 32'(sample_ready), 32'd0);
    check("por_level", 32'(level), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // T2: ordering F,E,D,C with level countdown
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 4'hE, 1'b0, 1'b0);
    cycle(1'b1, 4'hD, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
    check("t2_load", 32'(in_spikes), 32'hF);
    check("t2_lvl3", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("t2_adv", 32'(in_spikes), 32'(4'hE - 4'(i)));
      check("t2_lvl", 32'(level), 32'(2 - i));
      cycle(1'b0, '0, 1'b0, 1'b0);
    end

    // T1: reset mid-stream with data in flight
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h4, 1'b0, 1'b1);
    do_reset();

    // T3: sample held high advances exactly once
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_spikes", 32'(in_spikes), 32'h2);
    check("t3_level", 32'(level), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // T4: fill to full, overflow write never presented
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0);
    check("t4_level", 32'(level), 32'd8);
    check("t4_wr_ready", 32'(wr_ready), 32'd0);
    check("t4_ovf_pre", 32'(overflow), 32'd0);
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_level_keep", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("t4_drain", 32'(in_spikes), 32'(i + 2));
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t4_empty_spikes", 32'(in_spikes), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // T5: underrun, then reload after two clocks
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t5_flush_und", 32'(underrun), 32'd0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t5_first", 32'(in_spikes), 32'h5);
    check("t5_first_rdy", 32'(sample_ready), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t5_starve_rdy", 32'(sample_ready), 32'd0);
    check("t5_starve_spk", 32'(in_spikes), 32'd0);
    check("t5_underrun", 32'(underrun), 32'd1);
    cycle(1'b1, 4'h6, 1'b0, 1'b0);
    check("t5_lat1", 32'(sample_ready), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t5_lat2", 32'(sample_ready), 32'd1);
    check("t5_reload", 32'(in_spikes), 32'h6);

    // T6: flush beats write and rise; then balanced push/pop at level 3
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0);
    check("t6_lvl4", 32'(level), 32'd4);
    cycle(1'b1, 4'h7, 1'b1, 1'b1);
    check("t6_lvl0", 32'(level), 32'd0);
    check("t6_rdy0", 32'(sample_ready), 32'd0);
    check("t6_ovf0", 32'(overflow), 32'd0);
    check("t6_und0", 32'(underrun), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t6_nothing_enq", 32'(sample_ready), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0);
    check("t6_lvl3", 32'(level), 32'd3);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'(8 + i), 1'b0, 1'b1);
      check("t6_pp_lvl", 32'(level), 32'd3);
      check("t6_pp_data", 32'(in_spikes), (i < 3) ? 32'(i + 2) : 32'(8 + i - 3));
      cycle(1'b0, '0, 1'b0, 1'b0);
    end

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 99) < 55),
            4'($urandom),
            1'($urandom_range(0, 99) < 2),
            1'($urandom_range(0, 99) < 45));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
